// File: rtl/screen_scan_reader_pkg.sv
// ----------------------------------------------------------------------------
// screen_scan_reader_pkg
// Shared constants and types for the screen scan reader:
//   - screen geometry (512 x 256 monochrome, 16 pixels per RAM word)
//   - pixel coordinate widths
//   - scan FSM state encoding
// ----------------------------------------------------------------------------
package screen_scan_reader_pkg;

  localparam int SCREEN_WIDTH  = 512;
  localparam int SCREEN_HEIGHT = 256;
  localparam int WORD_WIDTH    = 16;
  localparam int PIX_PER_WORD  = 16;

  localparam int X_WIDTH = $clog2(SCREEN_WIDTH);
  localparam int Y_WIDTH = $clog2(SCREEN_HEIGHT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } scan_state_t;

endpackage

// File: rtl/screen_scan_reader_if.sv
// ----------------------------------------------------------------------------
// screen_scan_reader_if
// Bundles the RAM read port and the pixel stream of the scan reader.
//   mem_req / mem_grant / mem_address / mem_rdata : arbitrated RAM read
//   pix_valid / pix_ready / pix_value / pix_x / pix_y : pixel stream
// master = the scan reader, slave = RAM/arbiter plus display consumer.
// ----------------------------------------------------------------------------
interface screen_scan_reader_if #(
  parameter int ADDR_WIDTH = 14
);
  import screen_scan_reader_pkg::*;

  logic                  mem_req;
  logic                  mem_grant;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [WORD_WIDTH-1:0] mem_rdata;

  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix_value;
  logic [X_WIDTH-1:0]    pix_x;
  logic [Y_WIDTH-1:0]    pix_y;

  modport master (
    output mem_req, mem_address,
    input  mem_grant, mem_rdata,
    output pix_valid, pix_value, pix_x, pix_y,
    input  pix_ready
  );

  modport slave (
    input  mem_req, mem_address,
    output mem_grant, mem_rdata,
    input  pix_valid, pix_value, pix_x, pix_y,
    output pix_ready
  );

endinterface

// File: rtl/screen_word_fifo.sv
// ----------------------------------------------------------------------------
// screen_word_fifo
// Two-entry, 16-bit word FIFO between the RAM read data and the pixel shifter.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset (clears pointers/count)
//   i_push, i_data : write a word (ignored when full)
//   i_pop          : consume the head word (ignored when empty)
//   o_data         : head word (valid when o_count != 0)
//   o_count        : number of stored words, 0..2
// ----------------------------------------------------------------------------
module screen_word_fifo
  import screen_scan_reader_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic [WORD_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [WORD_WIDTH-1:0] o_data,
  output logic [1:0]            o_count
);

  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_do_push;
  logic       w_do_pop;

  assign w_do_push = i_push && (r_count != 2'd2);
  assign w_do_pop  = i_pop  && (r_count != 2'd0);

  // Storage entries carry no reset; only the pointers/count define contents.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [WORD_WIDTH-1:0] r_word;
    always_ff @(posedge i_clk) begin
      if (w_do_push && (r_wr_ptr == 1'(gi))) begin
        r_word <= i_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  assign o_data  = r_rd_ptr ? g_entry[1].r_word : g_entry[0].r_word;
  assign o_count = r_count;

endmodule

// File: rtl/screen_scan_reader.sv
// ----------------------------------------------------------------------------
// screen_scan_reader
// Scans one monochrome frame out of a 16-bit word RAM and serialises it into
// a pixel stream (LSB of each word is the leftmost pixel).
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_start        : one-cycle pulse, starts a frame when idle
//   o_busy         : frame in progress
//   o_frame_done   : one-cycle pulse after the final pixel transfers
//   bus (master)   : RAM read request/grant/address/data and pixel stream
// ----------------------------------------------------------------------------
module screen_scan_reader
  import screen_scan_reader_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 14,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    WORDS_PER_ROW = 32,
  parameter int                    ROWS          = 256
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_frame_done,
  screen_scan_reader_if.master bus
);

  localparam int                 TOTAL_WORDS = WORDS_PER_ROW * ROWS;
  localparam int                 IDX_W       = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(TOTAL_WORDS - 1);
  localparam logic [X_WIDTH-1:0] LAST_X      = X_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [Y_WIDTH-1:0] LAST_Y      = Y_WIDTH'(ROWS - 1);

  scan_state_t           r_state;
  scan_state_t           w_state_next;
  logic [IDX_W-1:0]      r_word_idx;
  logic [ADDR_WIDTH-1:0] r_address;
  logic                  r_inflight;
  logic [WORD_WIDTH-1:0] r_shift;
  logic [4:0]            r_remain;
  logic [X_WIDTH-1:0]    r_pix_x;
  logic [Y_WIDTH-1:0]    r_pix_y;
  logic                  r_frame_done;

  logic [1:0]            w_fifo_count;
  logic [WORD_WIDTH-1:0] w_fifo_data;
  logic                  w_mem_req;
  logic                  w_accept;
  logic                  w_pix_valid;
  logic                  w_xfer;
  logic                  w_load;
  logic                  w_last_xfer;
  logic                  w_start_ok;
  logic                  w_frame_end;

  // Word FIFO: the data of an accepted read is on mem_rdata in the cycle
  // after the grant edge, which is exactly when r_inflight is high.
  screen_word_fifo u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (r_inflight),
    .i_data  (bus.mem_rdata),
    .i_pop   (w_load),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count)
  );

  assign w_pix_valid = (r_remain != 5'd0);
  assign w_xfer      = w_pix_valid && bus.pix_ready;
  assign w_accept    = w_mem_req && bus.mem_grant;
  // Reload when empty, or on the transfer of the last bit so the stream has
  // no bubble between words.
  assign w_load      = (w_fifo_count != 2'd0) &&
                       (!w_pix_valid || ((r_remain == 5'd1) && w_xfer));
  assign w_last_xfer = w_xfer && (r_pix_x == LAST_X) && (r_pix_y == LAST_Y);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_mem_req    = 1'b0;
    w_start_ok   = 1'b0;
    w_frame_end  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_start_ok   = 1'b1;
          w_state_next = SCAN;
        end
      end
      SCAN: begin
        // Only request while there is guaranteed room for the returning word.
        w_mem_req = (({1'b0, w_fifo_count} + {2'b00, r_inflight}) < 3'd2);
        if (w_mem_req && bus.mem_grant && (r_word_idx == LAST_IDX)) begin
          w_state_next = FINISH;
        end
      end
      FINISH: begin
        if (w_last_xfer) begin
          w_frame_end  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------ read address path
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_word_idx   <= '0;
      r_address    <= BASE_ADDR;
      r_inflight   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_inflight   <= w_accept;
      r_frame_done <= w_frame_end;
      if (w_start_ok) begin
        r_word_idx <= '0;
        r_address  <= BASE_ADDR;
      end else if (w_accept) begin
        r_word_idx <= r_word_idx + 1'b1;
        r_address  <= r_address + 1'b1;   // wraps modulo 2^ADDR_WIDTH
      end
    end
  end

  // ---------------------------------------------------- pixel shifter path
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift  <= '0;
      r_remain <= 5'd0;
    end else if (w_load) begin
      r_shift  <= w_fifo_data;
      r_remain <= 5'(PIX_PER_WORD);
    end else if (w_xfer) begin
      r_shift  <= {1'b0, r_shift[WORD_WIDTH-1:1]};
      r_remain <= r_remain - 1'b1;
    end
  end

  // Coordinates follow the pixel order, so a plain raster counter suffices.
  // Clearing on frame end keeps a reduced ROWS setting restarting at (0,0).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pix_x <= '0;
      r_pix_y <= '0;
    end else if (w_start_ok || w_frame_end) begin
      r_pix_x <= '0;
      r_pix_y <= '0;
    end else if (w_xfer) begin
      if (r_pix_x == LAST_X) begin
        r_pix_x <= '0;
        r_pix_y <= r_pix_y + 1'b1;
      end else begin
        r_pix_x <= r_pix_x + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.mem_req     = w_mem_req;
  assign bus.mem_address = r_address;
  assign bus.pix_valid   = w_pix_valid;
  assign bus.pix_value   = r_shift[0];
  assign bus.pix_x       = r_pix_x;
  assign bus.pix_y       = r_pix_y;
  assign o_busy          = (r_state != IDLE);
  assign o_frame_done    = r_frame_done;

endmodule

// File: tb/tb_screen_scan_reader.sv
// ----------------------------------------------------------------------------
// tb_screen_scan_reader
// Directed bench for screen_scan_reader. Two instances share one RAM image:
// dut_a scans from word 0, dut_b from 14'h3FF0 (wraps to 0). A 4-row frame
// keeps each scan short while exercising the full 512-pixel row mapping.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_screen_scan_reader;
  import screen_scan_reader_pkg::*;

  localparam int ROWS_TB     = 4;
  localparam int WPR         = 32;
  localparam int TOTAL_WORDS = WPR * ROWS_TB;     // 128
  localparam int TOTAL_PIX   = TOTAL_WORDS * 16;  // 2048
  localparam int BASE_B      = 'h3FF0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, grant, ready, use_b, start_pend, mon_en;
  logic busy_a, done_a, busy_b, done_b;
  logic [15:0] rdata_a, rdata_b;
  logic [15:0] ram [0:16383];
  logic        got_pix [0:TOTAL_PIX-1];

  int n_checks, n_fail;
  int exp_idx, n_acc, n_done, cyc_cnt, gmode, rmode, base;
  int first_acc, first_val;

  screen_scan_reader_if #(.ADDR_WIDTH(14)) ifa ();
  screen_scan_reader_if #(.ADDR_WIDTH(14)) ifb ();

  wire start_a = start & ~use_b;
  wire start_b = start & use_b;

  screen_scan_reader #(.ADDR_WIDTH(14), .BASE_ADDR(14'h0000), .WORDS_PER_ROW(WPR), .ROWS(ROWS_TB)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_start(start_a), .o_busy(busy_a), .o_frame_done(done_a), .bus(ifa));
  screen_scan_reader #(.ADDR_WIDTH(14), .BASE_ADDR(14'h3FF0), .WORDS_PER_ROW(WPR), .ROWS(ROWS_TB)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_start(start_b), .o_busy(busy_b), .o_frame_done(done_b), .bus(ifb));

  // Synchronous-read RAM model: address sampled at the grant edge.
  always @(posedge clk) begin
    if (ifa.mem_req && grant) rdata_a <= ram[ifa.mem_address];
    if (ifb.mem_req && grant) rdata_b <= ram[ifb.mem_address];
  end

  assign ifa.mem_grant = grant;
  assign ifa.mem_rdata = rdata_a;
  assign ifa.pix_ready = ready;
  assign ifb.mem_grant = grant;
  assign ifb.mem_rdata = rdata_b;
  assign ifb.pix_ready = ready;

  wire        m_req   = use_b ? ifb.mem_req     : ifa.mem_req;
  wire [13:0] m_addr  = use_b ? ifb.mem_address : ifa.mem_address;
  wire        m_valid = use_b ? ifb.pix_valid   : ifa.pix_valid;
  wire        m_value = use_b ? ifb.pix_value   : ifa.pix_value;
  wire [8:0]  m_x     = use_b ? ifb.pix_x       : ifa.pix_x;
  wire [7:0]  m_y     = use_b ? ifb.pix_y       : ifa.pix_y;
  wire        m_busy  = use_b ? busy_b          : busy_a;
  wire        m_done  = use_b ? done_b          : done_a;
  wire [2:0]  m_occ   = use_b ? ({1'b0, dut_b.w_fifo_count} + {2'b00, dut_b.r_inflight})
                              : ({1'b0, dut_a.w_fifo_count} + {2'b00, dut_a.r_inflight});

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_pix(input int b, input int idx);
    logic [15:0] w;
    w = ram[(b + idx / 16) % 16384];
    return w[idx % 16];
  endfunction

  function automatic int sum_ones(input int lo, input int hi);
    int s;
    s = 0;
    for (int i = lo; i <= hi; i++) s += int'(got_pix[i]);
    return s;
  endfunction

  // Called at the falling edge once the inputs for the next rising edge are set.
  task automatic monitor();
    if (m_valid) begin
      if (first_val < 0) first_val = cyc_cnt;
      check_eq("pix_value", 32'(m_value), 32'(exp_pix(base, exp_idx)));
      check_eq("pix_x", 32'(m_x), 32'(exp_idx % 512));
      check_eq("pix_y", 32'(m_y), 32'(exp_idx / 512));
      if (ready) begin
        if (exp_idx < TOTAL_PIX) got_pix[exp_idx] = m_value;
        exp_idx++;
      end
    end
    if (m_req) begin
      check_eq("mem_address", 32'(m_addr), 32'((base + n_acc) % 16384));
      if (grant) begin
        if (first_acc < 0) first_acc = cyc_cnt;
        check_eq("read_in_range", 32'(n_acc < TOTAL_WORDS), 32'd1);
        n_acc++;
      end
    end
    check_eq("occupancy_le_2", 32'(m_occ <= 3'd2), 32'd1);
    if (m_occ >= 3'd2) check_eq("req_low_when_full", 32'(m_req), 32'd0);
    if (exp_idx > 0 && exp_idx < TOTAL_PIX) check_eq("busy_mid_frame", 32'(m_busy), 32'd1);
    if (m_done) begin
      n_done++;
      check_eq("done_after_last", 32'(exp_idx), 32'(TOTAL_PIX));
    end
  endtask

  task automatic step();
    @(negedge clk);
    start      = start_pend;
    start_pend = 1'b0;
    grant      = (gmode == 0) ? 1'b1 : (cyc_cnt % 4 == 0);
    ready      = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    cyc_cnt++;
    if (mon_en) monitor();
  endtask

  task automatic run_frame(input string name, input logic b, input int gm, input int rm,
                           input logic mid_start, input int stop_at);
    int cyc;
    use_b = b; gmode = gm; rmode = rm;
    base = b ? BASE_B : 0;
    exp_idx = 0; n_acc = 0; n_done = 0; first_acc = -1; first_val = -1;
    for (int i = 0; i < TOTAL_PIX; i++) got_pix[i] = 1'b0;
    start_pend = 1'b1;
    mon_en     = 1'b1;
    step();
    cyc = 0;
    while (n_done == 0 && cyc < 20000) begin
      if (mid_start && cyc == 300) start_pend = 1'b1;
      step();
      cyc++;
      if (stop_at > 0 && exp_idx >= stop_at && m_req && grant) break;
    end
    if (stop_at == 0) begin
      check_eq({name, "_done_pulse"}, 32'(n_done), 32'd1);
      check_eq({name, "_pixels"}, 32'(exp_idx), 32'(TOTAL_PIX));
      check_eq({name, "_reads"}, 32'(n_acc), 32'(TOTAL_WORDS));
      // Accept is observed one falling edge before its grant edge; the pixel
      // may appear no later than the falling edge after capture + load edges.
      check_eq({name, "_first_latency"}, 32'((first_val - first_acc) <= 3), 32'd1);
      repeat (3) step();
      check_eq({name, "_busy_after"}, 32'(m_busy), 32'd0);
      check_eq({name, "_single_done"}, 32'(n_done), 32'd1);
      $display("frame %s: %0d pixels, %0d reads, %0d cycles", name, exp_idx, n_acc, cyc);
    end else begin
      $display("frame %s: cut at pixel %0d after %0d reads", name, exp_idx, n_acc);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; start_pend = 1'b0; grant = 1'b0; ready = 1'b0;
    use_b = 1'b0; mon_en = 1'b0; gmode = 0; rmode = 0; cyc_cnt = 0; base = 0;
    exp_idx = 0; n_acc = 0; n_done = 0; first_acc = -1; first_val = -1;

    for (int i = 0; i < 16384; i++) ram[i] = 16'h0000;
    ram[0]         = 16'h0001;   // pixel (0,0)
    ram[5]         = 16'hA5C3;   // pixels 80..95
    ram[32]        = 16'h8000;   // pixel (15,1)
    ram[70]        = 16'h1234;
    ram[127]       = 16'hFFFF;   // pixels (496..511, last row)
    ram[14'h3FF0]  = 16'h0003;   // first word of the wrapped scan
    ram[14'h3FFF]  = 16'h8001;   // word just before the wrap

    repeat (3) @(negedge clk);
    check_eq("rst_busy",      32'(busy_a), 32'd0);
    check_eq("rst_done",      32'(done_a), 32'd0);
    check_eq("rst_req",       32'(ifa.mem_req), 32'd0);
    check_eq("rst_valid",     32'(ifa.pix_valid), 32'd0);
    check_eq("rst_value",     32'(ifa.pix_value), 32'd0);
    check_eq("rst_x",         32'(ifa.pix_x), 32'd0);
    check_eq("rst_y",         32'(ifa.pix_y), 32'd0);
    check_eq("rst_addr_a",    32'(ifa.mem_address), 32'h0000);
    check_eq("rst_addr_b",    32'(ifb.mem_address), 32'h3FF0);
    reset = 1'b0;

    // Full-rate frame plus hand-computed spot checks of the captured image.
    run_frame("base", 1'b0, 0, 0, 1'b0, 0);
    check_eq("px_0_0",       32'(got_pix[0]), 32'd1);
    check_eq("px_1to15",     32'(sum_ones(1, 15)), 32'd0);
    check_eq("px_15_1",      32'(got_pix[512 + 15]), 32'd1);
    check_eq("px_14_1",      32'(got_pix[512 + 14]), 32'd0);
    check_eq("px_80",        32'(got_pix[80]), 32'd1);
    check_eq("px_82",        32'(got_pix[82]), 32'd0);
    check_eq("px_last_word", 32'(sum_ones(TOTAL_PIX - 16, TOTAL_PIX - 1)), 32'd16);
    check_eq("px_2031",      32'(got_pix[TOTAL_PIX - 17]), 32'd0);
    check_eq("ones_base",    32'(sum_ones(0, TOTAL_PIX - 1)), 32'd31);

    run_frame("grant_1in4", 1'b0, 1, 0, 1'b0, 0);
    check_eq("ones_grant4", 32'(sum_ones(0, TOTAL_PIX - 1)), 32'd31);

    run_frame("rand_ready", 1'b0, 0, 1, 1'b0, 0);
    check_eq("ones_rready", 32'(sum_ones(0, TOTAL_PIX - 1)), 32'd31);

    run_frame("mid_start", 1'b0, 0, 0, 1'b1, 0);
    check_eq("ones_mstart", 32'(sum_ones(0, TOTAL_PIX - 1)), 32'd31);

    // Reset with a read in flight: the returning word must be discarded.
    run_frame("reset_cut", 1'b0, 0, 0, 1'b0, 1000);
    mon_en = 1'b0;
    step();
    reset = 1'b1;
    step();
    check_eq("cut_busy",  32'(busy_a), 32'd0);
    check_eq("cut_req",   32'(ifa.mem_req), 32'd0);
    check_eq("cut_valid", 32'(ifa.pix_valid), 32'd0);
    check_eq("cut_xy",    32'({ifa.pix_x, ifa.pix_y}), 32'd0);
    check_eq("cut_addr",  32'(ifa.mem_address), 32'h0000);
    reset = 1'b0;
    repeat (5) begin
      step();
      check_eq("cut_no_stale", 32'(ifa.pix_valid), 32'd0);
    end
    run_frame("after_reset", 1'b0, 0, 0, 1'b0, 0);
    check_eq("ones_after_reset", 32'(sum_ones(0, TOTAL_PIX - 1)), 32'd31);

    // Scan starting at 14'h3FF0: words 3FF0..3FFF then 0000..006F.
    run_frame("wrap", 1'b1, 0, 0, 1'b0, 0);
    check_eq("wrap_px0",   32'(got_pix[0]), 32'd1);
    check_eq("wrap_px1",   32'(got_pix[1]), 32'd1);
    check_eq("wrap_px2",   32'(got_pix[2]), 32'd0);
    check_eq("wrap_px240", 32'(got_pix[240]), 32'd1);
    check_eq("wrap_px255", 32'(got_pix[255]), 32'd1);
    check_eq("wrap_px256", 32'(got_pix[256]), 32'd1);
    check_eq("wrap_ones",  32'(sum_ones(0, TOTAL_PIX - 1)), 32'd19);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/screen_scan_reader.md
Name: screen_scan_reader

Overview:
- Read-side initiator for the 16-bit single-port word RAMs (sync read, 1-cycle latency, read only when not loading).
- Scans one full 512x256 monochrome screen frame from RAM.
- Fetches words sequentially under an external arbiter grant and serializes each word into pixels.
- Pixels leave on a valid/ready stream toward the display/video path.

Parameters:
- ADDR_WIDTH, 14, RAM word-address width.
- BASE_ADDR, 0, word address of pixel (0,0).
- WORDS_PER_ROW, 32, 16-bit words per screen row (512 px).
- ROWS, 256, screen rows per frame.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a frame scan when idle.
- busy  out  1  high from the cycle after an accepted start until frame_done.
- frame_done  out  1  one-cycle pulse after the last pixel transfers.
- mem_req  out  1  read request to arbiter.
- mem_grant  in  1  RAM samples mem_address in read mode at this edge.
- mem_address  out  ADDR_WIDTH  word address of the pending read.
- mem_rdata  in  16  RAM output; valid in the cycle after a granted edge.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  consumer accepts a pixel.
- pix_value  out  1  pixel bit (1 = black).
- pix_x  out  9  column 0..511.
- pix_y  out  8  row 0..255.

Behaviour:
- Reset values: busy, frame_done, mem_req, pix_valid, pix_value = 0; mem_address = BASE_ADDR; pix_x, pix_y = 0; FSM = IDLE; word counter, FIFO and in-flight flag cleared.
- FSM states: IDLE, SCAN, FINISH.
- IDLE -> SCAN on start.
- SCAN -> FINISH when the last read (word index WORDS_PER_ROW*ROWS-1) is granted.
- FINISH -> IDLE when the last pixel transfers; frame_done pulses on that transition.
- start while not IDLE is ignored.
- Read accept: mem_req && mem_grant at a posedge. The word is captured into the 2-deep word FIFO at the next posedge, so at most one read is in flight.
- mem_req = (state == SCAN) && (fifo_count + inflight < 2).
- mem_address = BASE_ADDR + word_index, wrapping modulo 2^ADDR_WIDTH.
- mem_address is held stable while mem_req && !mem_grant; it increments only on accept.
- No read is issued past the final word index.
- Shifter is a 16-bit register plus a 5-bit remaining count.
  - It loads from the FIFO when empty, or in the same cycle its last bit transfers (no bubble).
  - pix_valid = remaining != 0.
  - pix_value = shifter bit 0 (LSB = leftmost pixel); shift right on transfer.
- Pixel mapping: word w, bit b -> pix_x = (w mod WORDS_PER_ROW)*16 + b, pix_y = w / WORDS_PER_ROW. x/y counters advance on each transfer; pix_x wraps 511->0 with pix_y++.
- pix_value, pix_x and pix_y are stable while pix_valid && !pix_ready.
- Throughput: 1 pixel/cycle sustained with mem_grant asserted at least 1 in 16 cycles.
- First pixel valid no later than 2 cycles after the first accepted read (capture edge plus shifter load edge).
- Backpressure: a full FIFO drops mem_req; no data is ever dropped or duplicated.
- Reset mid-frame: next cycle returns to the reset values above. An in-flight read's data arriving after reset is discarded. A subsequent start rescans from (0,0).

Decomposition:
- Shared package: SCREEN_WIDTH=512, SCREEN_HEIGHT=256, WORD_WIDTH=16, PIX_PER_WORD=16, and the FSM state enum.
- Sub-module screen_word_fifo holds the 2-entry, 16-bit word FIFO (push/pop/count, synchronous reset).

Test Plan:
- Reset, start, grant=1, ready=1, RAM[0]=16'h0001, rest 0 -> first pixel (0,0)=1, next 15 pixels 0; exactly 131072 pixels total; frame_done single pulse after the last one; busy 0 afterwards.
- RAM[32]=16'h8000 -> only pixel (x=15,y=1) is 1; RAM[8191]=16'hFFFF -> pixels (496..511,255) all 1; no read issued at address 8192.
- mem_grant asserted 1 cycle in 4 -> mem_address stable between grants; fifo_count+inflight never exceeds 2; pixel stream identical to the grant=1 run.
- Random pix_ready (50%) -> pix_value/x/y unchanged while stalled; mem_req low while FIFO full; full frame matches the reference image.
- start pulsed mid-frame -> ignored, scan continues unchanged; reset asserted at pixel 5000 with a read in flight -> next cycle busy=0, mem_req=0, pix_valid=0; stale rdata not emitted; new start restarts at (0,0), address BASE_ADDR.
- BASE_ADDR=14'h3FF0 -> addresses wrap 3FFF->0000; pixel order preserved.
